// File: rtl/register_bank_if.sv
// Operand-read, write-back and issue signals shared by decode, write-back and the register bank.
interface register_bank_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] rs1_addr;
    logic [ADDR_WIDTH-1:0] rs2_addr;
    logic [WIDTH-1:0]      rs1_data;
    logic [WIDTH-1:0]      rs2_data;
    logic                  rs1_busy;
    logic                  rs2_busy;
    logic                  rd_we;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [WIDTH-1:0]      rd_data;
    logic                  issue_valid;
    logic [ADDR_WIDTH-1:0] issue_rd;
    logic                  any_busy;

    modport master (
        output rs1_addr, rs2_addr, rd_we, rd_addr, rd_data, issue_valid, issue_rd,
        input  rs1_data, rs2_data, rs1_busy, rs2_busy, any_busy
    );

    modport slave (
        input  rs1_addr, rs2_addr, rd_we, rd_addr, rd_data, issue_valid, issue_rd,
        output rs1_data, rs2_data, rs1_busy, rs2_busy, any_busy
    );
endinterface

// File: rtl/register_bank.sv
// Integer register file: two combinational read ports with write-back bypass,
// one write port, and a per-register pending-write scoreboard. x0 reads as zero.
module register_bank #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic           clk,
    input  logic           reset,
    register_bank_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] pending_next;

    logic wr_en;
    logic set_en;
    logic rs1_hit;
    logic rs2_hit;

    assign wr_en   = bus.rd_we && (bus.rd_addr != '0);
    assign set_en  = bus.issue_valid && (bus.issue_rd != '0);
    assign rs1_hit = wr_en && (bus.rd_addr == bus.rs1_addr);
    assign rs2_hit = wr_en && (bus.rd_addr == bus.rs2_addr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[bus.rd_addr] <= bus.rd_data;
        end
    end

    // Set is applied after clear so a newer issuing producer wins a collision.
    always_comb begin
        pending_next = pending;
        if (wr_en) begin
            pending_next[bus.rd_addr] = 1'b0;
        end
        if (set_en) begin
            pending_next[bus.issue_rd] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    always_comb begin
        bus.rs1_data = '0;
        bus.rs2_data = '0;
        if (bus.rs1_addr != '0) begin
            bus.rs1_data = rs1_hit ? bus.rd_data : regs[bus.rs1_addr];
        end
        if (bus.rs2_addr != '0) begin
            bus.rs2_data = rs2_hit ? bus.rd_data : regs[bus.rs2_addr];
        end
    end

    // pending[0] is never set, so index 0 is never busy without an extra term.
    assign bus.rs1_busy = pending[bus.rs1_addr] && !rs1_hit;
    assign bus.rs2_busy = pending[bus.rs2_addr] && !rs2_hit;
    assign bus.any_busy = |pending;
endmodule

// File: tb/tb_register_bank.sv
// Scoreboard bench for register_bank: directed scenarios plus random traffic against an array model.
module tb_register_bank;
    localparam int W = 32;
    localparam int A = 5;
    localparam int N = 32;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    register_bank_if #(.WIDTH(W), .ADDR_WIDTH(A)) bus ();

    register_bank #(.WIDTH(W), .ADDR_WIDTH(A)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        string          tag;
        logic [W-1:0]   d1;
        logic [W-1:0]   d2;
        logic           b1;
        logic           b2;
        logic           ab;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] model_regs [N];
    bit           model_pend [N];
    int           n_checks = 0;
    int           n_pass   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    function automatic void model_clear();
        for (int i = 0; i < N; i++) begin
            model_regs[i] = '0;
            model_pend[i] = 1'b0;
        end
    endfunction

    function automatic logic [W-1:0] model_read(input int addr);
        if (addr == 0) return '0;
        if (bus.rd_we && int'(bus.rd_addr) == addr) return bus.rd_data;
        return model_regs[addr];
    endfunction

    function automatic logic model_busy(input int addr);
        if (addr == 0) return 1'b0;
        return model_pend[addr] && !(bus.rd_we && int'(bus.rd_addr) == addr);
    endfunction

    function automatic logic model_any();
        logic r = 1'b0;
        for (int i = 0; i < N; i++) r = r | model_pend[i];
        return r;
    endfunction

    // One cycle: apply inputs after the edge, queue the expected outputs, then retire the edge in the model.
    task automatic step(input logic rst_v, input logic we, input int wa, input logic [W-1:0] wd,
                        input logic iv, input int ir, input int a1, input int a2, input string tag);
        exp_t e;
        reset           = rst_v;
        bus.rd_we       = we;
        bus.rd_addr     = A'(wa);
        bus.rd_data     = wd;
        bus.issue_valid = iv;
        bus.issue_rd    = A'(ir);
        bus.rs1_addr    = A'(a1);
        bus.rs2_addr    = A'(a2);
        if (rst_v) model_clear();
        e.tag = tag;
        e.d1  = model_read(a1);
        e.d2  = model_read(a2);
        e.b1  = model_busy(a1);
        e.b2  = model_busy(a2);
        e.ab  = model_any();
        exp_q.push_back(e);
        @(posedge clk);
        if (rst_v) begin
            model_clear();
        end else begin
            if (we && wa != 0) begin
                model_regs[wa] = wd;
                model_pend[wa] = 1'b0;
            end
            if (iv && ir != 0) model_pend[ir] = 1'b1;
        end
        #1;
    endtask

    task automatic idle(input int a1, input int a2, input string tag);
        step(1'b0, 1'b0, 0, '0, 1'b0, 0, a1, a2, tag);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.tag, ".rs1_data"}, bus.rs1_data, e.d1);
                check({e.tag, ".rs2_data"}, bus.rs2_data, e.d2);
                check({e.tag, ".rs1_busy"}, W'(bus.rs1_busy), W'(e.b1));
                check({e.tag, ".rs2_busy"}, W'(bus.rs2_busy), W'(e.b2));
                check({e.tag, ".any_busy"}, W'(bus.any_busy), W'(e.ab));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset           = 1'b1;
        bus.rd_we       = 1'b0;
        bus.rd_addr     = '0;
        bus.rd_data     = '0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.rs1_addr    = '0;
        bus.rs2_addr    = '0;
        model_clear();
        @(posedge clk);
        #1;

        step(1'b1, 1'b0, 0, '0, 1'b0, 0, 5, 7, "reset_state");
        idle(5, 7, "post_reset");

        step(1'b0, 1'b1, 5, 32'hDEADBEEF, 1'b1, 5, 5, 0, "wr_x5");
        idle(5, 5, "x5_held");
        step(1'b1, 1'b0, 0, '0, 1'b0, 0, 5, 5, "reset_clear");
        idle(5, 5, "after_reset");

        step(1'b0, 1'b1, 0, 32'hFFFFFFFF, 1'b1, 0, 0, 0, "x0_write");
        idle(0, 0, "x0_read1");
        idle(0, 0, "x0_read2");

        step(1'b0, 1'b1, 7, 32'h12345678, 1'b0, 0, 0, 7, "bypass");
        idle(0, 7, "bypass_held");

        step(1'b0, 1'b0, 0, '0, 1'b1, 3, 3, 0, "issue_x3");
        idle(3, 0, "x3_busy");
        step(1'b0, 1'b1, 3, 32'hA5, 1'b0, 0, 3, 3, "wb_x3");
        idle(3, 0, "x3_retired");

        step(1'b0, 1'b0, 0, '0, 1'b1, 9, 9, 0, "issue_x9");
        step(1'b0, 1'b1, 9, 32'h55, 1'b1, 9, 9, 9, "collide_x9");
        idle(9, 9, "x9_after");
        step(1'b0, 1'b1, 9, 32'h66, 1'b0, 0, 0, 0, "wb_x9");
        idle(9, 0, "x9_clear");

        step(1'b0, 1'b1, 1, 32'h11, 1'b0, 0, 0, 0, "wr_x1");
        step(1'b0, 1'b1, 2, 32'h22, 1'b0, 0, 0, 0, "wr_x2");
        idle(2, 1, "dual_port");

        for (int i = 0; i < N; i++) begin
            step(1'b0, 1'b1, i, (32'h01010101 * i) ^ 32'hA5A50F0F, 1'b0, 0, 0, 0, "walk_wr");
        end
        for (int i = 0; i < N; i++) begin
            idle(i, N - 1 - i, "walk_rd");
        end

        for (int k = 0; k < 2000; k++) begin
            int   a1, a2, wa;
            logic rs, we, iv;
            a1 = int'($urandom_range(0, N - 1));
            a2 = int'($urandom_range(0, N - 1));
            we = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0: wa = a1;
                1: wa = a2;
                default: wa = int'($urandom_range(0, N - 1));
            endcase
            iv = ($urandom_range(0, 1) != 0);
            rs = ($urandom_range(0, 199) == 0);
            step(rs, we, wa, W'($urandom), iv,
                 ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, N - 1)),
                 a1, a2, "random");
        end

        idle(0, 0, "drain");
        repeat (2) @(negedge clk);
        check("queue_drained", W'(exp_q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
